pfd: RTL and testbench
======================

Name: pfd

Overview:
- Sampled digital phase-frequency detector for the clock-recovery PLL.
- Compares rising edges of the reference clock (refclk) and the divided/feedback clock (finalclk), both treated as asynchronous data inputs oversampled by the system clock clk.
- Produces UP/DOWN pulses whose width, in clk cycles, equals the edge-time difference; these drive the downstream charge-pump/loop-filter model.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on refclk and finalclk (legal range 2..4).
- RST_DLY, 2, overlap cycles before clear when PFD_RESET_DELAY_EN is defined (legal range 1..15); unused otherwise.

Ports:
- clk  input  1  system sampling clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- d  input  1  PFD flop data/enable; 1 = edges may set up/down, 0 = no new assertions; quasi-static, sampled directly on clk.
- refclk  input  1  reference clock, asynchronous to clk.
- finalclk  input  1  feedback clock, asynchronous to clk.
- up  output  1  registered; high while refclk edge leads.
- down  output  1  registered; high while finalclk edge leads.

Behaviour:
- Reset (rst_n=0, asynchronous): all synchronizer, edge-history, up, down and counter flops go to 0 → up=0, down=0. On release, the first clk edge samples normally; no spurious edge is detected because history resets to 0 and a high input at release is seen as a rising edge only after propagating through the synchronizer.
- Synchronization: refclk and finalclk each pass through SYNC_STAGES flops; the last-stage output is ref_s / fb_s.
- Edge detection:
  - ref_rise = ref_s & ~ref_prev; fb_rise = fb_s & ~fb_prev; prev registers update every cycle.
  - Falling edges are ignored.
- Latency: input rising edge first captured at clk edge N → up/down asserts at clk edge N+SYNC_STAGES (3 cycles total with default).
- clear = up & down (registered values).
- Flag update, up shown (down identical with fb_rise):
  - If clear is active (or its delay expires, see Optional Feature): up_next = ref_rise & d. An edge coincident with the clear cycle re-arms the flag.
  - Else, if ref_rise & d: up_next = 1.
  - Else: hold.
- Pulse shape:
  - ref leads by k cycles → up high k+1 cycles, down high 1 cycle, overlapping in the last cycle.
  - fb leads → mirror image.
  - Coincident edges → up and down both high for exactly 1 cycle.
- Repeated edges on one input while its flag is already set: ignored (flag stays 1); no cycle-slip memory beyond one pending edge. This gives frequency-detect behaviour, where the faster input keeps its flag asserted.
- d=0: flags cannot be set, but an active clear still completes.
- Reset mid-pulse: up and down drop immediately (asynchronously).

Optional Feature:
- Macro PFD_RESET_DELAY_EN.
- Defined:
  - A 4-bit counter starts when up & down first become 1 and increments while both stay high.
  - Clear is applied when counter == RST_DLY-1, so overlap lasts exactly RST_DLY cycles; the counter then returns to 0.
  - Edges arriving during the overlap are ignored, except in the final clear cycle, where the re-arm rule applies.
  - Counter resets to 0 on rst_n.
- Not defined: no counter; overlap is exactly 1 cycle, as in Behaviour.

Test Plan:
- Reset: rst_n=0 with refclk/finalclk toggling → up=down=0 throughout; release with both inputs low → no pulse until a real rising edge.
- Ref leads: refclk rises 5 clk cycles before finalclk, d=1, defaults → up high 6 cycles starting 3 cycles after the refclk edge; down high 1 cycle; both low afterward.
- Fb leads: finalclk rises 3 cycles before refclk → down high 4 cycles, up high 1 cycle, overlapping in the last cycle.
- Coincident edges sampled in the same clk cycle → up=down=1 for exactly 1 cycle (RST_DLY cycles with PFD_RESET_DELAY_EN, e.g. 2).
- Frequency offset: clk period 1, refclk period 20, finalclk period 18 with offset 3, d=1, 10000 units → pulses alternate; down width grows by about 2 cycles per ref period until a finalclk cycle slip; never both high for more than 1 cycle (macro off).
- d=0 with both clocks toggling → up=down=0; assert rst_n=0 during an active up pulse → up drops immediately.

Source files
------------

// File: rtl/pfd.sv
// Sampled phase-frequency detector: synchronized refclk/finalclk rising edges set up/down; both high clears.
// Define PFD_RESET_DELAY_EN to hold the up/down overlap for RST_DLY cycles before the clear.
module pfd #(
  parameter int SYNC_STAGES = 2,
  parameter int RST_DLY     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic refclk,
  input  logic finalclk,
  output logic up,
  output logic down
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("pfd: SYNC_STAGES must be within 2..4");
  end
  if (RST_DLY < 1 || RST_DLY > 15) begin : g_bad_rst_dly
    $error("pfd: RST_DLY must be within 1..15");
  end

  // Channel 0 is refclk/up, channel 1 is finalclk/down.
  logic [SYNC_STAGES-1:0] ref_sync_reg;
  logic [SYNC_STAGES-1:0] fb_sync_reg;
  logic [1:0]             prev_reg;
  logic [1:0]             flag_reg;
  logic [1:0]             flag_next;
  logic [1:0]             sync_last;
  logic [1:0]             rise;
  logic                   both;
  logic                   clear;
  logic                   hold_ovl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_sync_reg <= '0;
      fb_sync_reg  <= '0;
      prev_reg     <= '0;
    end else begin
      ref_sync_reg <= {ref_sync_reg[SYNC_STAGES-2:0], refclk};
      fb_sync_reg  <= {fb_sync_reg[SYNC_STAGES-2:0], finalclk};
      prev_reg     <= sync_last;
    end
  end

  assign sync_last = {fb_sync_reg[SYNC_STAGES-1], ref_sync_reg[SYNC_STAGES-1]};
  assign rise      = sync_last & ~prev_reg;
  assign both      = flag_reg[0] & flag_reg[1];

`ifdef PFD_RESET_DELAY_EN
  localparam logic [3:0] CLR_AT = 4'(RST_DLY - 1);

  logic [3:0] cnt_reg;
  logic [3:0] cnt_next;

  // Overlap is counted from its first cycle; the clear lands on the RST_DLY-th.
  always_comb begin
    clear    = both && (cnt_reg == CLR_AT);
    hold_ovl = both && !clear;
    cnt_next = hold_ovl ? cnt_reg + 4'd1 : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 4'd0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`else
  always_comb begin
    clear    = both;
    hold_ovl = 1'b0;
  end
`endif

  // A rising edge in the clear cycle re-arms its flag instead of being lost.
  always_comb begin
    flag_next = flag_reg;
    for (int i = 0; i < 2; i++) begin
      if (clear) begin
        flag_next[i] = rise[i] & d;
      end else if (hold_ovl) begin
        flag_next[i] = flag_reg[i];
      end else if (rise[i] && d) begin
        flag_next[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_reg <= 2'b00;
    end else begin
      flag_reg <= flag_next;
    end
  end

  assign up   = flag_reg[0];
  assign down = flag_reg[1];

endmodule

// File: tb/tb_pfd.sv
// Directed bench for pfd (default build): per-cycle level patterns on refclk/finalclk/d
// with hand-derived up/down windows, plus reset and frequency-offset checks.
module tb_pfd;

  logic clk = 1'b0;
  logic rst_n;
  logic d;
  logic refclk;
  logic finalclk;
  logic up;
  logic down;

  int checks = 0;
  int errors = 0;

  pfd #(.SYNC_STAGES(2), .RST_DLY(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .refclk   (refclk),
    .finalclk (finalclk),
    .up       (up),
    .down     (down)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = (i >= lo) && (i <= hi);
    return r;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Cycle i: sample up/down at the negedge, then drive bit i of each level pattern.
  // An input rising at cycle k shows on its flag from cycle k+3.
  task automatic run(input string tag, input logic [31:0] ref_lv, input logic [31:0] fb_lv,
                     input logic [31:0] d_lv, input logic [31:0] exp_up, input logic [31:0] exp_dn);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk($sformatf("%s up[%0d]", tag, i), up, exp_up[i]);
      chk($sformatf("%s down[%0d]", tag, i), down, exp_dn[i]);
      refclk   = ref_lv[i];
      finalclk = fb_lv[i];
      d        = d_lv[i];
    end
    $display("run %s done: checks=%0d errors=%0d", tag, checks, errors);
  endtask

  initial begin
    logic prev_both;
    int   up_cycles;
    int   dn_cycles;

    rst_n    = 1'b0;
    d        = 1'b1;
    refclk   = 1'b0;
    finalclk = 1'b0;

    // Reset held while inputs toggle: outputs stay low.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("in_reset up[%0d]", i), up, 1'b0);
      chk($sformatf("in_reset down[%0d]", i), down, 1'b0);
      refclk   = ~refclk;
      finalclk = (i % 3) == 0;
    end
    @(negedge clk);
    refclk   = 1'b0;
    finalclk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run("idle_after_reset", 32'd0, 32'd0, '1, 32'd0, 32'd0);
    run("ref_leads_5", rng(0, 7), rng(5, 12), '1, rng(3, 8), rng(8, 8));
    run("fb_leads_3", rng(3, 10), rng(0, 7), '1, rng(6, 6), rng(3, 6));
    run("coincident", rng(0, 7), rng(0, 7), '1, rng(3, 3), rng(3, 3));
    run("rearm_on_clear", rng(0, 1) | rng(5, 12), rng(4, 7) | rng(10, 17), '1,
        rng(3, 13), rng(7, 7) | rng(13, 13));
    run("repeat_ref_edges", rng(0, 1) | rng(4, 5) | rng(8, 9), rng(14, 20), '1,
        rng(3, 17), rng(17, 17));
    run("d_low_clear_completes", rng(0, 7), rng(0, 7), rng(0, 2), rng(3, 3), rng(3, 3));
    run("d_low_toggling", rng(0, 3) | rng(8, 11) | rng(16, 19), rng(2, 5) | rng(12, 15),
        32'd0, 32'd0, 32'd0);
    run("up_pending", rng(0, 7), 32'd0, '1, rng(3, 31), 32'd0);

    // Asynchronous reset in mid-cycle while up is pending.
    @(negedge clk);
    chk("pre_async_reset up", up, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset up", up, 1'b0);
    chk("async_reset down", down, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run("after_async_reset", 32'd0, 32'd0, '1, 32'd0, 32'd0);

    // Frequency offset: ref period 20, fb period 18 offset 3; overlap never exceeds one cycle.
    prev_both = 1'b0;
    up_cycles = 0;
    dn_cycles = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      chk($sformatf("freq overlap[%0d]", c), up & down & prev_both, 1'b0);
      prev_both = up & down;
      if (up)   up_cycles++;
      if (down) dn_cycles++;
      refclk   = (c % 20) < 10;
      finalclk = ((c + 3) % 18) < 9;
    end
    chk("freq up_seen", up_cycles > 0, 1'b1);
    chk("freq down_seen", dn_cycles > 0, 1'b1);
    chk("freq down_dominates", dn_cycles > up_cycles, 1'b1);
    $display("freq offset: up_cycles=%0d down_cycles=%0d", up_cycles, dn_cycles);
    refclk   = 1'b0;
    finalclk = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
